// File: rtl/feedback_pkg.sv
// Shared types and constants for the USB feedback measurement controller.
package feedback_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DEF_TIMEOUT = 16'd60000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } fb_state_t;

endpackage

// File: rtl/sof_watchdog.sv
// Saturating SOF watchdog: down-counter reloaded on clear, expired at terminal count.
module sof_watchdog
  import feedback_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] remain;

  // Reload value makes the terminal count land exactly TIMEOUT cycles after a clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      remain <= TIMEOUT - ONE;
    end else if (run && (remain != '0)) begin
      remain <= remain - ONE;
    end
  end

  assign expired = run && (remain == '0);

endmodule

// File: rtl/feedback_ctrl.sv
// SOF-aligned feedback window sequencer and accumulator with valid/ready output.
// Optional build macro FB_CLAMP_EN clamps each window sample to [MIN_CNT, MAX_CNT].
//
// state | meaning
// IDLE  | measurement disabled, feedback_gen held in reset
// ARM   | waiting for first SOF edge, partial window discarded
// MEAS  | sampling cnt_in at every SOF edge, watchdog running
module feedback_ctrl
  import feedback_pkg::*;
#(
  parameter int               AVG_LOG2 = 3,
  parameter logic [CNT_W-1:0] TIMEOUT  = DEF_TIMEOUT,
  parameter logic [CNT_W-1:0] MIN_CNT  = 16'd0,
  parameter logic [CNT_W-1:0] MAX_CNT  = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      sof,
  input  logic [CNT_W-1:0]          cnt_in,
  output logic                      cnt_reset,
  output logic [CNT_W+AVG_LOG2-1:0] fb_data,
  output logic                      fb_valid,
  input  logic                      fb_ready,
  output logic                      overrun,
  output logic                      sof_lost
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] WIN_ONE = 1;

  fb_state_t state, state_nxt;

  logic              sof_q;
  logic              sof_edge;
  logic              timeout;
  logic [CNT_W-1:0]  sample;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [AVG_LOG2-1:0] win_cnt;
  logic [1:0]        rst_pulse;
  logic              take_sample;
  logic              load_result;

  assign sof_edge = sof & ~sof_q;

`ifdef FB_CLAMP_EN
  always_comb begin
    sample = cnt_in;
    if (cnt_in < MIN_CNT) begin
      sample = MIN_CNT;
    end else if (cnt_in > MAX_CNT) begin
      sample = MAX_CNT;
    end
  end
`else
  logic unused_clamp;
  assign unused_clamp = ^{MIN_CNT, MAX_CNT};
  assign sample = cnt_in;
`endif

  assign acc_sum     = acc + ACC_W'(sample);
  assign take_sample = (state == MEAS) && sof_edge;
  assign load_result = take_sample && (&win_cnt);

  sof_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (sof_edge || (state != MEAS)),
    .run    (state == MEAS),
    .expired(timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (sof_edge) state_nxt = MEAS;
        MEAS:    if (!sof_edge && timeout) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_reset = 1'b0;
    if ((state == IDLE) || rst_pulse[0]) begin
      cnt_reset = 1'b1;
    end
  end

  // Two-cycle reset pulse for feedback_gen starts the cycle after each SOF edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sof_q     <= 1'b0;
      rst_pulse <= '0;
      acc       <= '0;
      win_cnt   <= '0;
      fb_data   <= '0;
      fb_valid  <= 1'b0;
      overrun   <= 1'b0;
      sof_lost  <= 1'b0;
    end else begin
      sof_q <= sof;
      if (!enable) begin
        rst_pulse <= '0;
        acc       <= '0;
        win_cnt   <= '0;
        fb_valid  <= 1'b0;
        overrun   <= 1'b0;
        sof_lost  <= 1'b0;
      end else begin
        if (sof_edge && ((state == ARM) || (state == MEAS))) begin
          rst_pulse <= 2'b11;
        end else begin
          rst_pulse <= {1'b0, rst_pulse[1]};
        end

        if (take_sample) begin
          acc     <= load_result ? '0 : acc_sum;
          win_cnt <= win_cnt + WIN_ONE;
        end else if ((state == MEAS) && timeout) begin
          acc      <= '0;
          win_cnt  <= '0;
          sof_lost <= 1'b1;
        end

        if (load_result) begin
          fb_data  <= acc_sum;
          fb_valid <= 1'b1;
          if (fb_valid && !fb_ready) begin
            overrun <= 1'b1;
          end
        end else if (fb_valid && fb_ready) begin
          fb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_feedback_ctrl.sv
// Directed bench for feedback_ctrl (AVG_LOG2=2, TIMEOUT=100, MAX_CNT=2000).
module tb_feedback_ctrl;

  localparam int GAP = 30;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sof;
  logic [15:0] cnt_in;
  logic        cnt_reset;
  logic [17:0] fb_data;
  logic        fb_valid;
  logic        fb_ready;
  logic        overrun;
  logic        sof_lost;

  int tests;
  int fails;

  feedback_ctrl #(
    .AVG_LOG2(2),
    .TIMEOUT (16'd100),
    .MIN_CNT (16'd0),
    .MAX_CNT (16'd2000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .sof      (sof),
    .cnt_in   (cnt_in),
    .cnt_reset(cnt_reset),
    .fb_data  (fb_data),
    .fb_valid (fb_valid),
    .fb_ready (fb_ready),
    .overrun  (overrun),
    .sof_lost (sof_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle GAP cycles, then one-cycle SOF pulse carrying count c; returns in edge cycle + 1.
  task automatic window(input logic [15:0] c);
    repeat (GAP) tick();
    sof    = 1'b1;
    cnt_in = c;
    tick();
    sof    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    sof = 1'b0;
    cnt_in = '0;
    fb_ready = 1'b0;
    repeat (3) tick();
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL reset_cnt_reset got=%b exp=1", cnt_reset); end
    tests++; if (fb_data !== 18'd0) begin fails++; $display("FAIL reset_fb_data got=%0d exp=0", fb_data); end
    tests++; if (fb_valid !== 1'b0) begin fails++; $display("FAIL reset_fb_valid got=%b exp=0", fb_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    tests++; if (sof_lost !== 1'b0) begin fails++; $display("FAIL reset_sof_lost got=%b exp=0", sof_lost); end
    rst_n = 1'b1;
    tick();
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL idle_cnt_reset got=%b exp=1", cnt_reset); end
  endtask

  task automatic test_basic();
    enable = 1'b1;
    tick();
    tests++; if (cnt_reset !== 1'b0) begin fails++; $display("FAIL arm_cnt_reset got=%b exp=0", cnt_reset); end
    window(16'd1000);
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL pulse_e1 got=%b exp=1", cnt_reset); end
    tick();
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL pulse_e2 got=%b exp=1", cnt_reset); end
    tick();
    tests++; if (cnt_reset !== 1'b0) begin fails++; $display("FAIL pulse_e3 got=%b exp=0", cnt_reset); end
    for (int i = 0; i < 3; i++) window(16'd1000);
    tests++; if (fb_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got=%b exp=0", fb_valid); end
    window(16'd1000);
    tests++; if (fb_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got=%b exp=1", fb_valid); end
    tests++; if (fb_data !== 18'd4000) begin fails++; $display("FAIL basic_data got=%0d exp=4000", fb_data); end
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL basic_pulse got=%b exp=1", cnt_reset); end
  endtask

  task automatic test_overrun();
    window(16'd1000);
    window(16'd1001);
    window(16'd1001);
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    window(16'd1002);
    tests++; if (fb_data !== 18'd4004) begin fails++; $display("FAIL ovr_data got=%0d exp=4004", fb_data); end
    tests++; if (fb_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got=%b exp=1", fb_valid); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    fb_ready = 1'b1;
    tick();
    fb_ready = 1'b0;
    tests++; if (fb_valid !== 1'b0) begin fails++; $display("FAIL ovr_consume got=%b exp=0", fb_valid); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 4; i++) window(16'd2000);
    tests++; if (fb_data !== 18'd8000) begin fails++; $display("FAIL en_pre_data got=%0d exp=8000", fb_data); end
    window(16'd500);
    window(16'd500);
    enable = 1'b0;
    tick();
    tests++; if (fb_valid !== 1'b0) begin fails++; $display("FAIL en_valid got=%b exp=0", fb_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL en_overrun got=%b exp=0", overrun); end
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL en_cnt_reset got=%b exp=1", cnt_reset); end
    window(16'd123);
    tick();
    tests++; if (cnt_reset !== 1'b1) begin fails++; $display("FAIL en_cnt_reset_hold got=%b exp=1", cnt_reset); end
    enable = 1'b1;
    tick();
    tests++; if (cnt_reset !== 1'b0) begin fails++; $display("FAIL en_rearm got=%b exp=0", cnt_reset); end
    window(16'd9999);
    window(16'd1000);
    window(16'd1000);
    window(16'd1000);
    tests++; if (fb_valid !== 1'b0) begin fails++; $display("FAIL en_early_valid got=%b exp=0", fb_valid); end
    window(16'd1003);
    tests++; if (fb_valid !== 1'b1) begin fails++; $display("FAIL en_valid_after got=%b exp=1", fb_valid); end
    tests++; if (fb_data !== 18'd4003) begin fails++; $display("FAIL en_restart_data got=%0d exp=4003", fb_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) window(16'd1100);
    repeat (GAP) tick();
    sof      = 1'b1;
    cnt_in   = 16'd1100;
    fb_ready = 1'b1;
    tick();
    sof      = 1'b0;
    fb_ready = 1'b0;
    tests++; if (fb_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got=%b exp=1", fb_valid); end
    tests++; if (fb_data !== 18'd4400) begin fails++; $display("FAIL b2b_data got=%0d exp=4400", fb_data); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    fb_ready = 1'b1;
    tick();
    fb_ready = 1'b0;
    tests++; if (fb_valid !== 1'b0) begin fails++; $display("FAIL b2b_consume got=%b exp=0", fb_valid); end
  endtask

  task automatic test_timeout();
    window(16'd1000);
    window(16'd1000);
    repeat (99) tick();
    tests++; if (sof_lost !== 1'b0) begin fails++; $display("FAIL to_early got=%b exp=0", sof_lost); end
    tick();
    tests++; if (sof_lost !== 1'b1) begin fails++; $display("FAIL to_flag got=%b exp=1", sof_lost); end
    tests++; if (cnt_reset !== 1'b0) begin fails++; $display("FAIL to_cnt_reset got=%b exp=0", cnt_reset); end
    window(16'd9999);
    window(16'd1500);
    window(16'd1500);
    // Level-high SOF: only its first cycle is an edge, later count must be ignored.
    repeat (GAP) tick();
    sof    = 1'b1;
    cnt_in = 16'd1500;
    tick();
    cnt_in = 16'd7777;
    repeat (4) tick();
    sof    = 1'b0;
    tests++; if (fb_valid !== 1'b0) begin fails++; $display("FAIL to_early_valid got=%b exp=0", fb_valid); end
    window(16'd1500);
    tests++; if (fb_valid !== 1'b1) begin fails++; $display("FAIL to_valid got=%b exp=1", fb_valid); end
    tests++; if (fb_data !== 18'd6000) begin fails++; $display("FAIL to_data got=%0d exp=6000", fb_data); end
    tests++; if (sof_lost !== 1'b1) begin fails++; $display("FAIL to_sticky got=%b exp=1", sof_lost); end
    fb_ready = 1'b1;
    tick();
    fb_ready = 1'b0;
  endtask

`ifdef FB_CLAMP_EN
  task automatic test_clamp();
    window(16'd1000);
    window(16'd40000);
    window(16'd1000);
    window(16'd1000);
    tests++; if (fb_data !== 18'd5000) begin fails++; $display("FAIL clamp_data got=%0d exp=5000", fb_data); end
    tests++; if (fb_valid !== 1'b1) begin fails++; $display("FAIL clamp_valid got=%b exp=1", fb_valid); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_overrun();
    test_enable_drop();
    test_back_to_back();
    test_timeout();
`ifdef FB_CLAMP_EN
    test_clamp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/feedback_ctrl.md
Name: feedback_ctrl

Overview:
- Sequences the feedback_gen half-flag cycle counter against USB SOF timing.
- Aligns measurement windows to SOF and resets the counter at each window boundary. Captures each window's count, accumulates 2^AVG_LOG2 windows, and presents the sum to the FX2 endpoint logic over a valid/ready handshake.
- Sits between the SOF synchroniser and feedback_gen on one side, and the EP feedback packet builder on the other.

Parameters:
AVG_LOG2, 3, log2 of windows summed per result (1..6)
TIMEOUT, 16'd60000, clk cycles without an SOF edge before the window is declared lost
MIN_CNT, 16'd0, lower clamp per window (used only with FB_CLAMP_EN)
MAX_CNT, 16'hFFFF, upper clamp per window (used only with FB_CLAMP_EN)

Ports:
clk  in  1  ifclk, single clock domain
rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
enable  in  1  feedback measurement enabled (streaming alt-setting active)
sof  in  1  SOF level/pulse, already synchronised to clk
cnt_in  in  16  current count from feedback_gen
cnt_reset  out  1  drives feedback_gen reset input
fb_data  out  16+AVG_LOG2  summed feedback value
fb_valid  out  1  fb_data holds an unconsumed result
fb_ready  in  1  consumer accepts fb_data when fb_valid & fb_ready
overrun  out  1  sticky: an unconsumed result was overwritten
sof_lost  out  1  sticky: TIMEOUT expired while measuring

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, cnt_reset=1, fb_data=0, fb_valid=0, overrun=0, sof_lost=0. Accumulator, window counter and watchdog are cleared.
- SOF edge detection: sof_q is registered; sof_edge = sof & ~sof_q. A constantly high sof produces one edge only.
- IDLE: cnt_reset=1. When enable=1, go to ARM.
- ARM: cnt_reset=0. Wait for sof_edge; the partial window before the first SOF is discarded. On sof_edge, go to MEAS and fire the reset pulse.
- MEAS, on sof_edge in cycle E:
  - Sample cnt_in in cycle E (clamped if FB_CLAMP_EN); acc <= acc + sample; win_cnt <= win_cnt + 1.
  - cnt_reset=1 in cycles E+1 and E+2, then 0. The counts lost during the feedback_gen edge-detect latency are a fixed offset and are not compensated.
- Result: when the sample is taken with win_cnt = all-ones:
  - fb_data <= acc + sample at E+1, fb_valid=1 at E+1.
  - acc and win_cnt cleared (wrap). No extra cycle and no missed window.
- Accumulator width is 16+AVG_LOG2 and cannot overflow.
- Handshake:
  - fb_valid falls the cycle after fb_valid & fb_ready, unless a new result loads that cycle.
  - New result while fb_valid=1 and fb_ready=0: overwrite fb_data, fb_valid stays 1, overrun <= 1.
  - New result in the same cycle as fb_ready=1: old value consumed, new one loaded, fb_valid stays 1, overrun unchanged.
- Watchdog: counts cycles since the last sof_edge in MEAS and saturates. Reaching TIMEOUT:
  - state -> ARM; acc and win_cnt cleared; sof_lost <= 1.
  - fb_data and fb_valid are unaffected.
- enable deasserted in any state: next cycle state=IDLE, cnt_reset=1, fb_valid=0, acc, win_cnt, overrun and sof_lost cleared. Any in-flight partial average is dropped.
- sof_edge and timeout in the same cycle: the SOF wins and the watchdog is cleared.

Optional Feature:
- Macro: FB_CLAMP_EN.
- Defined: each sample is clamped to [MIN_CNT, MAX_CNT] before accumulation. Guards against glitched windows (e.g. half_n stuck).
- Undefined: cnt_in is accumulated raw, and MIN_CNT/MAX_CNT are unused.

Decomposition:
- Shared package (feedback_pkg):
  - state encoding typedef (IDLE, ARM, MEAS)
  - CNT_W=16 constant
  - default TIMEOUT constant
- One natural sub-module: sof_watchdog (saturating cycle counter with clear and expired output).
- SOF edge detect is inline; no pos_edge_det instance is needed, since that module uses an async reset.

Test Plan:
- AVG_LOG2=2, enable=1, SOF every 6000 clk, cnt_in=1000 at each edge -> first window discarded; fb_data=4000 and fb_valid=1 one cycle after the 5th SOF edge; cnt_reset high exactly 2 cycles after each edge.
- fb_ready held 0 across two results of 4000 then 4004 -> fb_data=4004, fb_valid=1, overrun=1; fb_ready pulse -> fb_valid=0 the next cycle.
- fb_ready=1 in the same cycle a new result loads -> fb_valid stays 1, overrun stays 0.
- TIMEOUT=100, stop SOF after 2 windows -> at cycle 100 after the last edge: sof_lost=1, state=ARM; the next result needs 1 discarded window plus 4 full windows.
- enable dropped mid-average, then reasserted -> fb_valid=0, flags cleared, cnt_reset=1 while disabled; sum restarts from 0.
- FB_CLAMP_EN, MAX_CNT=2000, one window cnt_in=40000, others 1000 -> result 5000.
